// File: rtl/adc_ctrl_avmm_initiator.sv
// Avalon-MM initiator for chipselect/write_n PIO responders; one outstanding access per command.
// Optional ADC_CTRL_READBACK_EN: every successful write is followed by a verifying read of the low byte.
module adc_ctrl_avmm_initiator #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] LAT_LAST = 2'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

`ifdef ADC_CTRL_READBACK_EN
  typedef enum logic [2:0] {IDLE, ACCESS, VERIFY, LAT, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCESS, LAT, RESP} state_t;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                write_reg, write_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [1:0]          lat_reg, lat_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic                sample_err;
`ifdef ADC_CTRL_READBACK_EN
  logic                verify_reg, verify_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      wdata_reg  <= '0;
      cnt_reg    <= '0;
      lat_reg    <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
`ifdef ADC_CTRL_READBACK_EN
      verify_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      write_reg  <= write_next;
      wdata_reg  <= wdata_next;
      cnt_reg    <= cnt_next;
      lat_reg    <= lat_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
`ifdef ADC_CTRL_READBACK_EN
      verify_reg <= verify_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    write_next  = write_reg;
    wdata_next  = wdata_reg;
    cnt_next    = cnt_reg;
    lat_next    = lat_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    sample_err  = 1'b0;
`ifdef ADC_CTRL_READBACK_EN
    verify_next = verify_reg;
    // Readback compares only the PIO's 8-bit register width.
    sample_err  = verify_reg && (avm_readdata[7:0] != wdata_reg[7:0]);
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next  = ACCESS;
          addr_next   = cmd_address;
          write_next  = cmd_write;
          wdata_next  = cmd_wdata;
          cnt_next    = '0;
          lat_next    = '0;
          err_next    = 1'b0;
`ifdef ADC_CTRL_READBACK_EN
          verify_next = 1'b0;
`endif
        end
      end
`ifdef ADC_CTRL_READBACK_EN
      ACCESS, VERIFY: begin
`else
      ACCESS: begin
`endif
        if (avm_waitrequest) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = '0;
          end
        end else if ((state_reg == ACCESS) && write_reg) begin
`ifdef ADC_CTRL_READBACK_EN
          // Each phase gets its own full timeout budget.
          state_next  = VERIFY;
          cnt_next    = '0;
          verify_next = 1'b1;
`else
          state_next = RESP;
          rdata_next = '0;
`endif
        end else if (RD_LATENCY == 0) begin
          state_next = RESP;
          rdata_next = avm_readdata;
          err_next   = sample_err;
        end else begin
          state_next = LAT;
          lat_next   = '0;
        end
      end
      LAT: begin
        if (lat_reg == LAT_LAST) begin
          state_next = RESP;
          rdata_next = avm_readdata;
          err_next   = sample_err;
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready     = (state_reg == IDLE);
  assign rsp_valid     = (state_reg == RESP);
  assign rsp_error     = rsp_valid && err_reg;
  assign rsp_rdata     = rdata_reg;
  assign avm_address   = addr_reg;
`ifdef ADC_CTRL_READBACK_EN
  assign avm_chipselect = (state_reg == ACCESS) || (state_reg == VERIFY);
`else
  assign avm_chipselect = (state_reg == ACCESS);
`endif
  assign avm_write_n   = !((state_reg == ACCESS) && write_reg);
  assign avm_writedata = avm_write_n ? '0 : wdata_reg;

endmodule

// File: tb/tb_adc_ctrl_avmm_initiator.sv
// Bench for adc_ctrl_avmm_initiator: two instances (RD_LATENCY 0/TIMEOUT 255, RD_LATENCY 2/TIMEOUT 4)
// driven by directed and random commands, checked against a command-level reference model.
module tb_adc_ctrl_avmm_initiator;

  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid[2], cmd_ready[2], cmd_write[2];
  logic [1:0]  cmd_address[2];
  logic [31:0] cmd_wdata[2];
  logic        rsp_valid[2], rsp_error[2];
  logic [31:0] rsp_rdata[2];
  logic [1:0]  avm_address[2];
  logic        avm_chipselect[2], avm_write_n[2], avm_waitrequest[2];
  logic [31:0] avm_writedata[2], avm_readdata[2];

  logic [7:0]  pio_mem[2][4];
  logic [7:0]  ref_mem[2][4];
  logic [7:0]  corrupt;
  int          n_vec = 0;
  int          n_err = 0;

  adc_ctrl_avmm_initiator #(.ADDR_W(2), .DATA_W(32), .RD_LATENCY(0), .TIMEOUT(255)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_address(cmd_address[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]),
    .avm_address(avm_address[0]), .avm_chipselect(avm_chipselect[0]), .avm_write_n(avm_write_n[0]),
    .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]), .avm_waitrequest(avm_waitrequest[0])
  );

  adc_ctrl_avmm_initiator #(.ADDR_W(2), .DATA_W(32), .RD_LATENCY(2), .TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_address(cmd_address[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]),
    .avm_address(avm_address[1]), .avm_chipselect(avm_chipselect[1]), .avm_write_n(avm_write_n[1]),
    .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]), .avm_waitrequest(avm_waitrequest[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? 255 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command on instance k and plays the PIO responder; waitrequest is held for
  // the first w chipselect cycles of the transaction. Entered and left on a negedge.
  task automatic run_txn(input int k, input bit wr, input logic [1:0] a, input logic [31:0] d, input int w);
    int lat, to, cyc, waited, rd_cyc, wr_cs, rd_cs, rsp_cyc, bad_addr, bad_wd, bad_rdy;
    int exp_wr_cs, exp_rd_cs, exp_rsp_cyc;
    logic [1:0]  rd_a;
    logic [31:0] got_rdata, exp_rdata;
    logic        got_err, exp_err, done, strobe;
    lat = lat_of(k);
    to  = to_of(k);

    if (w >= to) begin
      exp_err = 1'b1; exp_rdata = '0; exp_rsp_cyc = to + 1;
      exp_wr_cs = wr ? to : 0; exp_rd_cs = wr ? 0 : to;
    end else if (wr) begin
      ref_mem[k][a] = d[7:0] ^ corrupt;
      exp_wr_cs = w + 1;
`ifdef ADC_CTRL_READBACK_EN
      exp_rd_cs = 1; exp_rsp_cyc = w + 3 + lat;
      exp_rdata = {24'h0, ref_mem[k][a]}; exp_err = (ref_mem[k][a] != d[7:0]);
`else
      exp_rd_cs = 0; exp_rsp_cyc = w + 2; exp_rdata = '0; exp_err = 1'b0;
`endif
    end else begin
      exp_wr_cs = 0; exp_rd_cs = w + 1; exp_rsp_cyc = w + 2 + lat;
      exp_rdata = {24'h0, ref_mem[k][a]}; exp_err = 1'b0;
    end

    chk("ready_before_cmd", cmd_ready[k], 1);
    cmd_valid[k] = 1'b1; cmd_write[k] = wr; cmd_address[k] = a; cmd_wdata[k] = d;
    avm_waitrequest[k] = 1'b0; avm_readdata[k] = GARBAGE;
    cyc = 0; waited = 0; rd_cyc = -100; rd_a = '0; wr_cs = 0; rd_cs = 0; rsp_cyc = 0;
    bad_addr = 0; bad_wd = 0; bad_rdy = 0; got_rdata = '0; got_err = 1'b0; done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rsp_cyc != 0) begin
        chk("ready_after_rsp", cmd_ready[k], 1);
        chk("rsp_one_cycle", rsp_valid[k], 0);
        done = 1'b1;
      end else begin
        if (cmd_ready[k]) bad_rdy++;
        if (rsp_valid[k]) begin
          rsp_cyc = cyc; got_rdata = rsp_rdata[k]; got_err = rsp_error[k];
        end
        if (avm_chipselect[k]) begin
          if (avm_address[k] !== a) bad_addr++;
          if (avm_write_n[k]) rd_cs++;
          else begin
            wr_cs++;
            if (avm_writedata[k] !== d) bad_wd++;
          end
        end
        avm_waitrequest[k] = avm_chipselect[k] && (waited < w);
        if (avm_waitrequest[k]) waited++;
        strobe = avm_chipselect[k] && !avm_waitrequest[k];
        if (strobe && !avm_write_n[k]) pio_mem[k][avm_address[k]] = avm_writedata[k][7:0] ^ corrupt;
        if (strobe && avm_write_n[k]) begin
          rd_cyc = cyc; rd_a = avm_address[k];
        end
        avm_readdata[k] = (cyc == rd_cyc + lat) ? {24'h0, pio_mem[k][rd_a]} : GARBAGE;
        // Busy-time junk on the command port must be ignored.
        cmd_valid[k]   = rsp_valid[k] ? 1'b0 : 1'($urandom_range(0, 1));
        cmd_write[k]   = 1'($urandom_range(0, 1));
        cmd_address[k] = 2'($urandom_range(0, 3));
        cmd_wdata[k]   = $urandom;
      end
    end
    cmd_valid[k] = 1'b0;
    avm_waitrequest[k] = 1'b0;
    chk("rsp_seen", done, 1);
    chk("rsp_cycle", rsp_cyc, exp_rsp_cyc);
    chk("rsp_rdata", got_rdata, exp_rdata);
    chk("rsp_error", got_err, exp_err);
    chk("write_cs_cycles", wr_cs, exp_wr_cs);
    chk("read_cs_cycles", rd_cs, exp_rd_cs);
    chk("address_stable", bad_addr, 0);
    chk("writedata_stable", bad_wd, 0);
    chk("ready_low_busy", bad_rdy, 0);
    $display("txn dut%0d %s a=%0d d=%08h w=%0d rsp_cyc=%0d rdata=%08h err=%0d", k, wr ? "WR" : "RD",
             a, d, w, rsp_cyc, got_rdata, got_err);
  endtask

  initial begin
    reset = 1'b1;
    corrupt = 8'h00;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0; cmd_address[k] = '0; cmd_wdata[k] = '0;
      avm_waitrequest[k] = 1'b0; avm_readdata[k] = GARBAGE;
      for (int r = 0; r < 4; r++) begin
        pio_mem[k][r] = 8'h00; ref_mem[k][r] = 8'h00;
      end
    end
    // Reset with a pending read on instance 0.
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_address[0] = 2'd1; cmd_wdata[0] = '1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cmd_ready", cmd_ready[k], 1);
      chk("rst_rsp_valid", rsp_valid[k], 0);
      chk("rst_rsp_rdata", rsp_rdata[k], 0);
      chk("rst_rsp_error", rsp_error[k], 0);
      chk("rst_chipselect", avm_chipselect[k], 0);
      chk("rst_write_n", avm_write_n[k], 1);
      chk("rst_address", avm_address[k], 0);
      chk("rst_writedata", avm_writedata[k], 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_accept_cs", avm_chipselect[0], 1);
    chk("first_accept_addr", avm_address[0], 1);
    cmd_valid[0] = 1'b0;
    repeat (4) @(negedge clk);

    run_txn(0, 1'b1, 2'd0, 32'h0000_00A5, 0);
    chk("pio_out_port", pio_mem[0][0], 8'hA5);
    run_txn(0, 1'b0, 2'd0, 32'h0, 0);
    run_txn(1, 1'b1, 2'd0, 32'h0000_00A5, 0);
    run_txn(1, 1'b0, 2'd0, 32'h0, 0);
    run_txn(0, 1'b0, 2'd0, 32'h0, 10);
    run_txn(1, 1'b0, 2'd2, 32'h0, 50);
    run_txn(1, 1'b1, 2'd3, 32'h0000_0077, 9);
    corrupt = 8'h10;
    run_txn(0, 1'b1, 2'd1, 32'h0000_005A, 0);
    run_txn(1, 1'b1, 2'd1, 32'h0000_005A, 1);
    corrupt = 8'h00;
    run_txn(0, 1'b1, 2'd1, 32'h0000_005A, 0);
    run_txn(1, 1'b1, 2'd1, 32'h0000_005A, 0);

    // Reset in the middle of a stalled access.
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_address[0] = 2'd2; cmd_wdata[0] = 32'h12;
    avm_waitrequest[0] = 1'b1;
    @(negedge clk);
    chk("midrst_cs_before", avm_chipselect[0], 1);
    cmd_valid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs_dropped", avm_chipselect[0], 0);
    chk("midrst_no_rsp", rsp_valid[0], 0);
    reset = 1'b0;
    avm_waitrequest[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp_later", rsp_valid[0], 0);
    end
    chk("midrst_ready", cmd_ready[0], 1);

    for (int i = 0; i < 40; i++) begin
      int k, r, w;
      k = i % 2;
      r = $urandom_range(0, 9);
      w = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? 10 : to_of(k) + $urandom_range(0, 3);
      corrupt = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'h00;
      run_txn(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
